// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared encodings and helpers for the memory bus adapter
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_DONE    = 2'b10,
        ST_RELEASE = 2'b11
    } state_e;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int TIMEOUT_DEFAULT = 255;
    localparam int CNT_W           = 16;

    // Only real bus operations can be misaligned; no-ops always report aligned.
    function automatic logic is_aligned(input logic [1:0] op,
                                        input logic [1:0] size,
                                        input logic [1:0] addr_lo);
        logic bad;
        bad = (size == 2'b11) ||
              (size == SZ_HALF && addr_lo[0]) ||
              (size == SZ_WORD && addr_lo != 2'b00);
        return !((op == OP_LOAD || op == OP_STORE) && bad);
    endfunction

endpackage

// File: rtl/mem_bus_if.sv
// rtl/mem_bus_if.sv - word-addressed memory bus with byte enables
interface mem_bus_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane enables, store replication and load extension
module mem_lane_align
    import mem_bus_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sign,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    // Lane enables and store data replication so any lane sees the right bytes
    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be        = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = wdata;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0 and extend it to 32 bits
    always_comb begin
        shifted   = mem_rdata >> {addr_lo, 3'b000};
        rdata_ext = mem_rdata;
        case (size)
            SZ_BYTE: rdata_ext = {{24{sign & shifted[7]}}, shifted[7:0]};
            SZ_HALF: rdata_ext = {{16{sign & shifted[15]}}, shifted[15:0]};
            default: rdata_ext = mem_rdata;
        endcase
    end

endmodule

// File: rtl/mem_bus_adapter.sv
// rtl/mem_bus_adapter.sv - control-FSM load/store request to memory bus cycle adapter
module mem_bus_adapter
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_mem,
    input  logic [1:0]   W_R_mem,
    input  logic [1:0]   wordsize_mem,
    input  logic         sign_mem,
    input  logic [31:0]  addr,
    input  logic [31:0]  wdata,
    output logic [31:0]  rdata,
    output logic         busy_mem,
    output logic         done_mem,
    output logic         aligned_mem,
    output logic         bus_err,
    mem_bus_if.master    bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [1:0]       size_q, size_d;
    logic             sign_q, sign_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [3:0]       lane_be;
    logic [31:0]      lane_wdata;
    logic [31:0]      lane_rdata;
    logic             in_req;
    logic             is_mem_op;

    assign aligned_mem = is_aligned(W_R_mem, wordsize_mem, addr[1:0]);
    assign is_mem_op   = (W_R_mem == OP_LOAD) || (W_R_mem == OP_STORE);

    // Lane logic runs off the latched request so the bus stays stable during REQ
    mem_lane_align u_lane (
        .size      (size_q),
        .addr_lo   (addr_q[1:0]),
        .sign      (sign_q),
        .wdata     (wdata_q),
        .mem_rdata (bus.mem_rdata),
        .be        (lane_be),
        .wdata_rep (lane_wdata),
        .rdata_ext (lane_rdata)
    );

    // Next-state, request latching, wait counter and result capture
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        size_d  = size_q;
        sign_d  = sign_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (en_mem) begin
                    if (is_mem_op && aligned_mem) begin
                        op_d    = W_R_mem;
                        size_d  = wordsize_mem;
                        sign_d  = sign_mem;
                        addr_d  = addr;
                        wdata_d = wdata;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = ST_REQ;
                    end else if (!is_mem_op) begin
                        err_d   = 1'b0;
                        state_d = ST_DONE;
                    end
                    // misaligned request: stay here and let the control FSM trap
                end
            end
            ST_REQ: begin
                if (bus.mem_ack) begin
                    if (op_q == OP_LOAD) begin
                        rdata_d = lane_rdata;
                    end
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!en_mem) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            size_q  <= SZ_BYTE;
            sign_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Bus outputs are only driven while a request is in flight
    assign in_req        = (state_q == ST_REQ);
    assign bus.mem_req   = in_req;
    assign bus.mem_we    = in_req && (op_q == OP_STORE);
    assign bus.mem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus.mem_be    = in_req ? lane_be : 4'b0000;
    assign bus.mem_wdata = in_req ? lane_wdata : 32'h0;

    assign busy_mem = in_req;
    assign done_mem = (state_q == ST_DONE);
    assign rdata    = rdata_q;
    assign bus_err  = err_q;

endmodule

// File: tb/tb_mem_bus_adapter.sv
// tb/tb_mem_bus_adapter.sv - directed self-checking bench for mem_bus_adapter
module tb_mem_bus_adapter;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_mem;
    logic [1:0]  W_R_mem;
    logic [1:0]  wordsize_mem;
    logic        sign_mem;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy_mem;
    logic        done_mem;
    logic        aligned_mem;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    mem_bus_if bus ();

    always #5 clk = ~clk;

    mem_bus_adapter #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .en_mem       (en_mem),
        .W_R_mem      (W_R_mem),
        .wordsize_mem (wordsize_mem),
        .sign_mem     (sign_mem),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .busy_mem     (busy_mem),
        .done_mem     (done_mem),
        .aligned_mem  (aligned_mem),
        .bus_err      (bus_err),
        .bus          (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int req_cycles;

        reset = 1'b0;
        en_mem = 1'b0; W_R_mem = 2'b00; wordsize_mem = 2'b00; sign_mem = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        step(); step();

        check("rst_mem_req",  32'(bus.mem_req), 0);
        check("rst_busy",     32'(busy_mem), 0);
        check("rst_done",     32'(done_mem), 0);
        check("rst_bus_err",  32'(bus_err), 0);
        check("rst_rdata",    rdata, 32'h0);
        check("rst_mem_be",   32'(bus.mem_be), 0);
        check("rst_aligned",  32'(aligned_mem), 1);

        reset = 1'b1;
        step();

        // load byte 0x103 sign-extended, ack on third REQ cycle
        en_mem = 1'b1; W_R_mem = 2'b01; wordsize_mem = 2'b00; sign_mem = 1'b1; addr = 32'h103;
        #1;
        check("lb_aligned", 32'(aligned_mem), 1);
        step();
        check("lb_req",     32'(bus.mem_req), 1);
        check("lb_busy",    32'(busy_mem), 1);
        check("lb_addr",    bus.mem_addr, 32'h100);
        check("lb_be",      32'(bus.mem_be), 32'h8);
        check("lb_we",      32'(bus.mem_we), 0);
        check("lb_nodone",  32'(done_mem), 0);
        step();
        check("lb_req2",    32'(bus.mem_req), 1);
        step();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h80123456;
        step();
        bus.mem_ack = 1'b0;
        check("lb_done",    32'(done_mem), 1);
        check("lb_rdata",   rdata, 32'hFFFFFF80);
        check("lb_req_off", 32'(bus.mem_req), 0);
        step();
        check("lb_done_1cyc", 32'(done_mem), 0);
        en_mem = 1'b0;
        step();

        // store half 0x22, ack already high so completion is at N+2
        en_mem = 1'b1; W_R_mem = 2'b10; wordsize_mem = 2'b01; sign_mem = 1'b0;
        addr = 32'h22; wdata = 32'h1234ABCD; bus.mem_ack = 1'b1;
        step();
        check("sh_we",     32'(bus.mem_we), 1);
        check("sh_be",     32'(bus.mem_be), 32'hC);
        check("sh_wdata",  bus.mem_wdata, 32'hABCDABCD);
        check("sh_addr",   bus.mem_addr, 32'h20);
        check("sh_nodone", 32'(done_mem), 0);
        step();
        check("sh_done",   32'(done_mem), 1);
        check("sh_rdata_hold", rdata, 32'hFFFFFF80);
        bus.mem_ack = 1'b0; en_mem = 1'b0;
        step(); step();

        // misaligned word load traps in IDLE
        en_mem = 1'b1; W_R_mem = 2'b01; wordsize_mem = 2'b10; addr = 32'h41;
        #1;
        check("lw_mis_aligned", 32'(aligned_mem), 0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.mem_req || done_mem || busy_mem) seen++;
        end
        check("lw_mis_quiet", seen, 0);
        en_mem = 1'b0;
        W_R_mem = 2'b10; wordsize_mem = 2'b01; addr = 32'h23; #1;
        check("al_half_odd", 32'(aligned_mem), 0);
        W_R_mem = 2'b01; wordsize_mem = 2'b11; addr = 32'h0; #1;
        check("al_size11", 32'(aligned_mem), 0);
        W_R_mem = 2'b00; wordsize_mem = 2'b11; addr = 32'h41; #1;
        check("al_nop", 32'(aligned_mem), 1);
        W_R_mem = 2'b10; wordsize_mem = 2'b01; addr = 32'h22; #1;
        check("al_half_even", 32'(aligned_mem), 1);
        step();

        // timeout with TIMEOUT=4 and no ack
        en_mem = 1'b1; W_R_mem = 2'b01; wordsize_mem = 2'b10; addr = 32'h44;
        step();
        req_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            if (done_mem) break;
            if (bus.mem_req) req_cycles++;
            step();
        end
        check("to_req_cycles", req_cycles, 4);
        check("to_done",       32'(done_mem), 1);
        check("to_bus_err",    32'(bus_err), 1);
        check("to_rdata_hold", rdata, 32'hFFFFFF80);
        en_mem = 1'b0;
        step(); step();

        // zero-extended byte load from lane 2, en held after completion
        en_mem = 1'b1; W_R_mem = 2'b01; wordsize_mem = 2'b00; sign_mem = 1'b0; addr = 32'h2;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h00AB0000;
        step();
        check("lbu_err_clear", 32'(bus_err), 0);
        check("lbu_be",        32'(bus.mem_be), 32'h4);
        step();
        check("lbu_done",  32'(done_mem), 1);
        check("lbu_rdata", rdata, 32'h000000AB);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.mem_req || done_mem) seen++;
        end
        check("held_en_no_retrigger", seen, 0);
        bus.mem_ack = 1'b0; en_mem = 1'b0;
        step(); step();

        // sign-extended half load from upper lanes
        en_mem = 1'b1; W_R_mem = 2'b01; wordsize_mem = 2'b01; sign_mem = 1'b1; addr = 32'h6;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h80011234;
        step();
        check("lh_be",   32'(bus.mem_be), 32'hC);
        check("lh_addr", bus.mem_addr, 32'h4);
        step();
        check("lh_rdata", rdata, 32'hFFFF8001);
        bus.mem_ack = 1'b0; en_mem = 1'b0;
        step(); step();

        // no-op completes without a bus cycle
        en_mem = 1'b1; W_R_mem = 2'b00;
        step();
        check("nop_done",  32'(done_mem), 1);
        check("nop_noreq", 32'(bus.mem_req), 0);
        check("nop_rdata", rdata, 32'hFFFF8001);
        en_mem = 1'b0;
        step(); step();

        // reset asserted in the middle of a store
        en_mem = 1'b1; W_R_mem = 2'b10; wordsize_mem = 2'b10; addr = 32'h80; wdata = 32'h55;
        step();
        check("mid_req_on", 32'(bus.mem_req), 1);
        reset = 1'b0;
        #1;
        check("mid_rst_req",   32'(bus.mem_req), 0);
        check("mid_rst_busy",  32'(busy_mem), 0);
        check("mid_rst_be",    32'(bus.mem_be), 0);
        check("mid_rst_rdata", rdata, 32'h0);
        en_mem = 1'b0;
        step();
        reset = 1'b1;
        step();
        check("post_rst_idle", 32'(bus.mem_req), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_adapter.md
MEM_BUS_ADAPTER -- requirements
Module: mem_bus_adapter

Interface
REQ-001 SHALL have parameter: TIMEOUT, 255, max cycles in REQ waiting for mem_ack before abort (legal 2..65535).
REQ-002 SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: en_mem  in  1  level request from control FSM, held until done_mem.
REQ-005 SHALL have port: W_R_mem  in  2  op: 01 load, 10 store, 00/11 no-op.
REQ-006 SHALL have port: wordsize_mem  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-007 SHALL have port: sign_mem  in  1  1 = sign-extend load, 0 = zero-extend.
REQ-008 SHALL have port: addr  in  32  byte address.
REQ-009 SHALL have port: wdata  in  32  store data, right-justified.
REQ-010 SHALL have port: rdata  out  32  extended load result.
REQ-011 SHALL have port: busy_mem  out  1  bus cycle in flight.
REQ-012 SHALL have port: done_mem  out  1  one-cycle completion pulse.
REQ-013 SHALL have port: aligned_mem  out  1  combinational alignment of current addr/wordsize_mem.
REQ-014 SHALL have port: bus_err  out  1  last access timed out.
REQ-015 SHALL have ports: mem_req out 1, mem_we out 1, mem_addr out 32, mem_be out 4, mem_wdata out 32 (bus request side).
REQ-016 SHALL have ports: mem_rdata in 32, mem_ack in 1 (bus response side).

Function
REQ-017 SHALL implement states IDLE, REQ, DONE, RELEASE.
REQ-018 aligned_mem SHALL be 0 when op is load/store and (size 11, or half with addr[0]=1, or word with addr[1:0]!=0); else 1.
REQ-019 IDLE with en_mem=1, load/store, aligned: SHALL latch addr, wdata, size, sign, op; go REQ next cycle.
REQ-020 IDLE with en_mem=1 and misaligned: SHALL stay IDLE, no bus cycle, no done_mem (FSM traps).
REQ-021 IDLE with en_mem=1 and no-op: SHALL go DONE next cycle without bus access.
REQ-022 In REQ: mem_req=1, busy_mem=1, mem_addr={addr[31:2],2'b00}, mem_we=1 only for store; all stable until exit.
REQ-023 mem_be SHALL be byte 4'b0001<<addr[1:0], half 4'b0011<<addr[1:0], word 4'b1111; 0 outside REQ.
REQ-024 mem_wdata SHALL be byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-025 mem_ack=1 in REQ SHALL exit to DONE next cycle; load captures selected lane of mem_rdata into rdata, extended per sign_mem.
REQ-026 mem_ack outside REQ SHALL be ignored.
REQ-027 Wait counter SHALL clear on REQ entry; no ack by TIMEOUT-th REQ cycle -> DONE with bus_err=1, rdata unchanged.
REQ-028 DONE SHALL last exactly one cycle with done_mem=1, then RELEASE.
REQ-029 RELEASE SHALL hold until en_mem=0, then IDLE; no retrigger from held en_mem.
REQ-030 bus_err SHALL clear when next request is accepted; rdata SHALL hold until next completed load.
REQ-031 Latency: accept cycle N, mem_req from N+1; ack at cycle M -> done_mem at M+1; zero-wait ack -> done_mem at N+2.

Reset
REQ-032 reset=0 SHALL immediately force IDLE and zero all outputs except aligned_mem (combinational); mem_req drops mid-transaction.
REQ-033 Deasserting reset SHALL start in IDLE with counter 0, bus_err 0, rdata 0.

Structure
REQ-034 Package mem_bus_pkg SHALL hold state enum, W_R_mem and wordsize encodings, TIMEOUT default.
REQ-035 Combinational sub-module mem_lane_align SHALL compute mem_be, mem_wdata replication, lane select and extension.

Verification
REQ-036 Load byte addr 0x103, sign=1, mem_rdata 0x80xxxxxx, ack after 3 cycles -> mem_be 1000, rdata 0xFFFFFF80, one done_mem pulse.
REQ-037 Store half addr 0x22, wdata 0x1234ABCD, ack immediate -> mem_we=1, mem_be 1100, mem_wdata 0xABCDABCD, done at N+2.
REQ-038 Load word addr 0x41 -> aligned_mem=0, mem_req never high, no done_mem.
REQ-039 TIMEOUT=4, no ack -> mem_req high 4 cycles, done_mem with bus_err=1, rdata unchanged.
REQ-040 en_mem held high 5 cycles after done_mem -> no second mem_req; reset=0 mid-REQ -> mem_req and busy_mem 0 same cycle.
